// File: rtl/disp_refresh_ctrl.sv
// Display refresh controller: periodically snapshots a selected display word and launches a
// serial transfer with a one-cycle Start pulse. Optional blink divider built with DISP_FLASH_EN.
module disp_refresh_ctrl #(
  parameter int unsigned REFRESH_CYCLES = 1048576,
  parameter int unsigned HOLD_CYCLES    = 256,
  parameter int unsigned FLASH_DIV      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  sel,
  input  logic [31:0] data0,
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  input  logic [31:0] data3,
  input  logic [7:0]  point_in,
  input  logic [7:0]  les_in,
  input  logic        text_in,
  input  logic        refresh_req,
  output logic [31:0] Hexs,
  output logic [7:0]  point,
  output logic [7:0]  LES,
  output logic        Text,
  output logic        Start,
  output logic        flash,
  output logic        busy
);

  localparam logic [23:0] RefLast  = 24'(REFRESH_CYCLES - 1);
  localparam logic [23:0] HoldLast = 24'(HOLD_CYCLES - 1);

  if (REFRESH_CYCLES < 8 || REFRESH_CYCLES > 2 ** 24) begin : g_bad_refresh
    $error("REFRESH_CYCLES out of range");
  end
  if (HOLD_CYCLES < 1 || HOLD_CYCLES >= REFRESH_CYCLES) begin : g_bad_hold
    $error("HOLD_CYCLES out of range");
  end
  if (FLASH_DIV < 1 || FLASH_DIV > 255) begin : g_bad_flash
    $error("FLASH_DIV out of range");
  end

  typedef enum logic [1:0] {StIdle, StLatch, StStart, StHold} state_e;

  state_e      state_q, state_d;
  logic [23:0] refresh_cnt_q, refresh_cnt_d;
  logic [23:0] hold_cnt_q, hold_cnt_d;
  logic        pending_q, pending_d;
  logic [31:0] hexs_q;
  logic [7:0]  point_q;
  logic [7:0]  les_q;
  logic        text_q;
  logic        refresh_evt;
  logic        busy_w;
  logic [31:0] sel_word;

  always_comb begin
    refresh_evt   = (refresh_cnt_q == RefLast);
    busy_w        = (state_q != StIdle);
    state_d       = state_q;
    hold_cnt_d    = hold_cnt_q;
    pending_d     = pending_q;
    refresh_cnt_d = refresh_evt ? 24'd0 : refresh_cnt_q + 24'd1;

    unique case (state_q)
      StIdle: begin
        if (refresh_evt || refresh_req || pending_q) begin
          state_d   = StLatch;
          pending_d = 1'b0;
        end
        // The request cycle itself counts as count 0, so the next period restarts from it.
        if (refresh_req) begin
          refresh_cnt_d = 24'd1;
        end
      end
      StLatch: state_d = StStart;
      StStart: begin
        state_d    = StHold;
        hold_cnt_d = 24'd0;
      end
      StHold: begin
        if (hold_cnt_q == HoldLast) begin
          state_d = StIdle;
        end else begin
          hold_cnt_d = hold_cnt_q + 24'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (busy_w && (refresh_evt || refresh_req)) begin
      pending_d = 1'b1;
    end
  end

  always_comb begin
    sel_word = data0;
    unique case (sel)
      2'd0: sel_word = data0;
      2'd1: sel_word = data1;
      2'd2: sel_word = data2;
      2'd3: sel_word = data3;
      default: sel_word = data0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      refresh_cnt_q <= 24'd0;
      hold_cnt_q    <= 24'd0;
      pending_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      refresh_cnt_q <= refresh_cnt_d;
      hold_cnt_q    <= hold_cnt_d;
      pending_q     <= pending_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hexs_q  <= 32'd0;
      point_q <= 8'd0;
      les_q   <= 8'd0;
      text_q  <= 1'b0;
    end else if (state_q == StLatch) begin
      hexs_q  <= sel_word;
      point_q <= point_in;
      les_q   <= les_in;
      text_q  <= text_in;
    end
  end

  assign Hexs  = hexs_q;
  assign point = point_q;
  assign LES   = les_q;
  assign Text  = text_q;
  assign Start = (state_q == StStart);
  assign busy  = busy_w;

`ifdef DISP_FLASH_EN
  logic [7:0] flash_div_q;
  logic       flash_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      flash_div_q <= 8'd0;
      flash_q     <= 1'b0;
    end else if (Start) begin
      if (flash_div_q == 8'(FLASH_DIV - 1)) begin
        flash_div_q <= 8'd0;
        flash_q     <= ~flash_q;
      end else begin
        flash_div_q <= flash_div_q + 8'd1;
      end
    end
  end

  assign flash = flash_q;
`else
  assign flash = 1'b0;
`endif

endmodule

// File: tb/tb_disp_refresh_ctrl.sv
// Directed bench for disp_refresh_ctrl (REFRESH_CYCLES=16, HOLD_CYCLES=4, FLASH_DIV=2).
// Cycle c is the clock period following the c-th edge after the reset release point.
module tb_disp_refresh_ctrl;

  logic        clk;
  logic        rst;
  logic [1:0]  sel;
  logic [31:0] data0, data1, data2, data3;
  logic [7:0]  point_in, les_in;
  logic        text_in, refresh_req;
  logic [31:0] Hexs;
  logic [7:0]  point, LES;
  logic        Text, Start, flash, busy;

  int n_cmp;
  int n_err;
  int cyc;

  disp_refresh_ctrl #(
    .REFRESH_CYCLES(16),
    .HOLD_CYCLES   (4),
    .FLASH_DIV     (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sel        (sel),
    .data0      (data0),
    .data1      (data1),
    .data2      (data2),
    .data3      (data3),
    .point_in   (point_in),
    .les_in     (les_in),
    .text_in    (text_in),
    .refresh_req(refresh_req),
    .Hexs       (Hexs),
    .point      (point),
    .LES        (LES),
    .Text       (Text),
    .Start      (Start),
    .flash      (flash),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  // Hand-derived timeline: refreshes latch at 16, 26 (req@25), 41 (auto), 48 (pending),
  // 57 (auto); rst pulse during 60 takes effect at 61; next auto latch at 77.
  function automatic logic exp_start(input int c);
    return (c == 17 || c == 27 || c == 42 || c == 49 || c == 58 || c == 78);
  endfunction

  function automatic logic exp_busy(input int c);
    return (c >= 16 && c <= 21) || (c >= 26 && c <= 31) || (c >= 41 && c <= 46) ||
           (c >= 48 && c <= 53) || (c >= 57 && c <= 60) || (c >= 77 && c <= 82);
  endfunction

  function automatic logic exp_flash(input int c);
`ifdef DISP_FLASH_EN
    return (c >= 28 && c <= 49);
`else
    return (c < 0);
`endif
  endfunction

  function automatic logic [31:0] exp_hexs(input int c);
    if (c >= 17 && c <= 26) return 32'h1234_5678;
    if (c >= 27 && c <= 48) return 32'hDEAD_BEEF;
    if (c >= 49 && c <= 57) return 32'hCAFE_F00D;
    if ((c >= 58 && c <= 60) || c >= 78) return 32'h0F0F_0F0F;
    return 32'd0;
  endfunction

  function automatic logic [7:0] exp_point(input int c);
    if (c >= 17 && c <= 26) return 8'hA5;
    if ((c >= 27 && c <= 60) || c >= 78) return 8'h5A;
    return 8'h00;
  endfunction

  function automatic logic [7:0] exp_les(input int c);
    if (c >= 17 && c <= 26) return 8'h3C;
    if ((c >= 27 && c <= 60) || c >= 78) return 8'hC3;
    return 8'h00;
  endfunction

  task automatic drive(input int c);
    unique case (c)
      19: begin
        data2    = 32'hDEAD_BEEF;
        sel      = 2'd0;
        point_in = 8'h5A;
        les_in   = 8'hC3;
        text_in  = 1'b0;
      end
      22: sel = 2'd2;
      25, 43, 45: refresh_req = 1'b1;
      26, 44, 46: refresh_req = 1'b0;
      47: sel = 2'd1;
      50: sel = 2'd3;
      60: rst = 1'b1;
      61: rst = 1'b0;
      default: ;
    endcase
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    cyc         = 0;
    rst         = 1'b1;
    sel         = 2'd2;
    data0       = 32'h0BAD_F00D;
    data1       = 32'hCAFE_F00D;
    data2       = 32'h1234_5678;
    data3       = 32'h0F0F_0F0F;
    point_in    = 8'hA5;
    les_in      = 8'h3C;
    text_in     = 1'b1;
    refresh_req = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_start", {31'd0, Start}, 32'd0);
    rst = 1'b0;

    for (int c = 0; c <= 84; c++) begin
      cyc = c;
      check_eq("start", {31'd0, Start}, {31'd0, exp_start(c)});
      check_eq("busy", {31'd0, busy}, {31'd0, exp_busy(c)});
      check_eq("flash", {31'd0, flash}, {31'd0, exp_flash(c)});
      check_eq("hexs", Hexs, exp_hexs(c));
      check_eq("point", {24'd0, point}, {24'd0, exp_point(c)});
      check_eq("les", {24'd0, LES}, {24'd0, exp_les(c)});
      check_eq("text", {31'd0, Text}, {31'd0, (c >= 17 && c <= 26)});
      drive(c);
      @(posedge clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
